// File: rtl/bp_serializer_if.sv
// Handshake bundle for bp_serializer: wide ready/valid input, narrow ready/valid output, beat index.
// last_o is present only when BP_SERIALIZER_LAST_EN is defined.
interface bp_serializer_if #(
    parameter int NARROWW = 8,
    parameter int RATIO   = 4
);
    localparam int CNTW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [NARROWW*RATIO-1:0] data_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [NARROWW-1:0]       data_o;
    logic                     valid_o;
    logic                     ready_i;
    logic [CNTW-1:0]          beat_o;

    // slave is the serializer itself; master is whatever surrounds it (upstream and downstream)
`ifdef BP_SERIALIZER_LAST_EN
    logic                     last_o;
    modport slave  (input  data_i, valid_i, ready_i,
                    output ready_o, data_o, valid_o, beat_o, last_o);
    modport master (output data_i, valid_i, ready_i,
                    input  ready_o, data_o, valid_o, beat_o, last_o);
`else
    modport slave  (input  data_i, valid_i, ready_i,
                    output ready_o, data_o, valid_o, beat_o);
    modport master (output data_i, valid_i, ready_i,
                    input  ready_o, data_o, valid_o, beat_o);
`endif
endinterface

// File: rtl/bp_serializer.sv
// Full-throughput wide-to-narrow serializer: one NARROWW*RATIO word in, RATIO narrow beats out.
// Optional last_o output enabled by defining BP_SERIALIZER_LAST_EN.
module bp_serializer #(
    parameter int NARROWW   = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bp_serializer_if.slave bus
);
    localparam int CNTW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(RATIO - 1);

    typedef enum logic {Idle, Busy} state_e;

    state_e                        state_q, state_d;
    logic [CNTW-1:0]               cnt_q, cnt_d;
    logic [RATIO-1:0][NARROWW-1:0] hold_q, hold_d;

    logic            lastBeat;
    logic            inFire;
    logic            outFire;
    logic [CNTW-1:0] sliceIdx;

    // ready_o depends only on ready_i and state, never on valid_i
    assign lastBeat    = (state_q == Busy) && (cnt_q == LAST_IDX);
    assign bus.ready_o = (state_q == Idle) || (bus.ready_i && lastBeat);
    assign bus.valid_o = (state_q == Busy);
    assign inFire      = bus.valid_i && bus.ready_o;
    assign outFire     = bus.valid_o && bus.ready_i;
    assign sliceIdx    = MSB_FIRST ? (LAST_IDX - cnt_q) : cnt_q;
    assign bus.data_o  = hold_q[sliceIdx];
    assign bus.beat_o  = cnt_q;

`ifdef BP_SERIALIZER_LAST_EN
    assign bus.last_o  = lastBeat;
`endif

    // A new word wins over the last-beat retire so the handover happens without a bubble
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        if (inFire) begin
            hold_d  = bus.data_i;
            cnt_d   = '0;
            state_d = Busy;
        end else if (outFire) begin
            if (lastBeat) begin
                cnt_d   = '0;
                state_d = Idle;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end
endmodule

// File: tb/tb_bp_serializer.sv
// Directed bench for bp_serializer: LSB-first, MSB-first and RATIO=1 instances on one clock.
// last_o checks are compiled in only when BP_SERIALIZER_LAST_EN is defined.
module tb_bp_serializer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bp_serializer_if #(.NARROWW(8), .RATIO(4)) m  ();
    bp_serializer_if #(.NARROWW(8), .RATIO(4)) mf ();
    bp_serializer_if #(.NARROWW(8), .RATIO(1)) r1 ();

    bp_serializer #(.NARROWW(8), .RATIO(4), .MSB_FIRST(1'b0)) uMain (.clk_i(clk), .rst_i(rst), .bus(m.slave));
    bp_serializer #(.NARROWW(8), .RATIO(4), .MSB_FIRST(1'b1)) uMsb  (.clk_i(clk), .rst_i(rst), .bus(mf.slave));
    bp_serializer #(.NARROWW(8), .RATIO(1), .MSB_FIRST(1'b0)) uR1   (.clk_i(clk), .rst_i(rst), .bus(r1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (m.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b want=0", m.valid_o); end
        checks++; if (m.data_o !== 8'h00) begin failures++; $display("[TB] FAIL rst_data got=%h want=00", m.data_o); end
        checks++; if (m.beat_o !== 2'd0) begin failures++; $display("[TB] FAIL rst_beat got=%0d want=0", m.beat_o); end
        checks++; if (m.ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready got=%b want=1", m.ready_o); end
        checks++; if (mf.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_msb_valid got=%b want=0", mf.valid_o); end
        checks++; if (r1.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_r1_valid got=%b want=0", r1.valid_o); end
`ifdef BP_SERIALIZER_LAST_EN
        checks++; if (m.last_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_last got=%b want=0", m.last_o); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (m.ready_o !== 1'b1 || m.valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_release got ready=%b valid=%b want ready=1 valid=0", m.ready_o, m.valid_o);
        end
        tick();
    endtask

    task automatic test_single();
        logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        m.data_i = 32'hDDCCBBAA; m.valid_i = 1'b1; m.ready_i = 1'b1;
        #1;
        checks++; if (m.ready_o !== 1'b1) begin failures++; $display("[TB] FAIL single_accept_ready got=%b want=1", m.ready_o); end
        tick();
        m.valid_i = 1'b0; m.data_i = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (m.valid_o !== 1'b1 || m.data_o !== exp[i] || m.beat_o !== 2'(i)) begin
                failures++; $display("[TB] FAIL single_beat%0d got valid=%b data=%h beat=%0d want valid=1 data=%h beat=%0d", i, m.valid_o, m.data_o, m.beat_o, exp[i], i);
            end
            checks++; if (m.ready_o !== (i == 3)) begin failures++; $display("[TB] FAIL single_ready%0d got=%b want=%b", i, m.ready_o, (i == 3)); end
`ifdef BP_SERIALIZER_LAST_EN
            checks++; if (m.last_o !== (i == 3)) begin failures++; $display("[TB] FAIL single_last%0d got=%b want=%b", i, m.last_o, (i == 3)); end
`endif
            tick();
        end
        #1;
        checks++; if (m.valid_o !== 1'b0 || m.ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL single_idle got valid=%b ready=%b want valid=0 ready=1", m.valid_o, m.ready_o);
        end
    endtask

    task automatic test_back_to_back();
        m.data_i = 32'h04030201; m.valid_i = 1'b1; m.ready_i = 1'b1;
        tick();
        m.data_i = 32'h08070605;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (m.valid_o !== 1'b1 || m.data_o !== 8'(i + 1) || m.beat_o !== 2'(i % 4)) begin
                failures++; $display("[TB] FAIL b2b_beat%0d got valid=%b data=%h beat=%0d want valid=1 data=%h beat=%0d", i, m.valid_o, m.data_o, m.beat_o, 8'(i + 1), i % 4);
            end
            checks++; if (m.ready_o !== ((i % 4) == 3)) begin
                failures++; $display("[TB] FAIL b2b_ready%0d got=%b want=%b", i, m.ready_o, ((i % 4) == 3));
            end
            tick();
            if (i == 3) begin
                m.valid_i = 1'b0; m.data_i = '0;
            end
        end
        #1;
        checks++; if (m.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got=%b want=0", m.valid_o); end
    endtask

    task automatic test_backpressure();
        m.data_i = 32'h44332211; m.valid_i = 1'b1; m.ready_i = 1'b1;
        tick();
        m.valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (m.data_o !== 8'(8'h11 * (i + 1))) begin
                failures++; $display("[TB] FAIL bp_pre%0d got=%h want=%h", i, m.data_o, 8'(8'h11 * (i + 1)));
            end
            tick();
        end
        m.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (m.valid_o !== 1'b1 || m.data_o !== 8'h33 || m.beat_o !== 2'd2 || m.ready_o !== 1'b0) begin
                failures++; $display("[TB] FAIL bp_hold%0d got valid=%b data=%h beat=%0d ready=%b want 1/33/2/0", i, m.valid_o, m.data_o, m.beat_o, m.ready_o);
            end
            tick();
        end
        m.ready_i = 1'b1;
        #1;
        checks++; if (m.data_o !== 8'h33 || m.beat_o !== 2'd2 || m.ready_o !== 1'b0) begin
            failures++; $display("[TB] FAIL bp_resume got data=%h beat=%0d ready=%b want 33/2/0", m.data_o, m.beat_o, m.ready_o);
        end
        tick();
        #1;
        checks++; if (m.data_o !== 8'h44 || m.beat_o !== 2'd3 || m.ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL bp_last got data=%h beat=%0d ready=%b want 44/3/1", m.data_o, m.beat_o, m.ready_o);
        end
        tick();
        #1;
        checks++; if (m.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle got=%b want=0", m.valid_o); end
    endtask

    task automatic test_msb_first();
        logic [7:0] exp [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        mf.data_i = 32'hDDCCBBAA; mf.valid_i = 1'b1; mf.ready_i = 1'b1;
        tick();
        mf.valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (mf.valid_o !== 1'b1 || mf.data_o !== exp[i] || mf.beat_o !== 2'(i)) begin
                failures++; $display("[TB] FAIL msb_beat%0d got valid=%b data=%h beat=%0d want valid=1 data=%h beat=%0d", i, mf.valid_o, mf.data_o, mf.beat_o, exp[i], i);
            end
            tick();
        end
        #1;
        checks++; if (mf.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL msb_idle got=%b want=0", mf.valid_o); end
    endtask

    task automatic test_ratio1();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        r1.valid_i = 1'b1; r1.ready_i = 1'b1; r1.data_i = words[0];
        #1;
        checks++; if (r1.ready_o !== 1'b1) begin failures++; $display("[TB] FAIL r1_ready_idle got=%b want=1", r1.ready_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) r1.data_i = words[i + 1];
            else       r1.valid_i = 1'b0;
            #1;
            checks++; if (r1.valid_o !== 1'b1 || r1.data_o !== words[i] || r1.beat_o !== 1'b0 || r1.ready_o !== 1'b1) begin
                failures++; $display("[TB] FAIL r1_beat%0d got valid=%b data=%h beat=%0d ready=%b want 1/%h/0/1", i, r1.valid_o, r1.data_o, r1.beat_o, r1.ready_o, words[i]);
            end
            tick();
        end
        #1;
        checks++; if (r1.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL r1_idle got=%b want=0", r1.valid_o); end
        r1.data_i = 8'h5A; r1.valid_i = 1'b1;
        tick();
        r1.valid_i = 1'b0; r1.ready_i = 1'b0;
        #1;
        checks++; if (r1.ready_o !== 1'b0 || r1.data_o !== 8'h5A) begin
            failures++; $display("[TB] FAIL r1_stall got ready=%b data=%h want ready=0 data=5a", r1.ready_o, r1.data_o);
        end
        r1.ready_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_word();
        m.data_i = 32'hA5A4A3A2; m.valid_i = 1'b1; m.ready_i = 1'b1;
        tick();
        m.valid_i = 1'b0;
        #1;
        checks++; if (m.data_o !== 8'hA2) begin failures++; $display("[TB] FAIL mid_beat0 got=%h want=a2", m.data_o); end
        tick();
        #1;
        checks++; if (m.beat_o !== 2'd1 || m.data_o !== 8'hA3) begin
            failures++; $display("[TB] FAIL mid_beat1 got beat=%0d data=%h want 1/a3", m.beat_o, m.data_o);
        end
        rst = 1'b1;
        #1;
        checks++; if (m.valid_o !== 1'b0 || m.data_o !== 8'h00 || m.beat_o !== 2'd0 || m.ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL mid_rst got valid=%b data=%h beat=%0d ready=%b want 0/00/0/1", m.valid_o, m.data_o, m.beat_o, m.ready_o);
        end
        rst = 1'b0;
        m.data_i = 'x;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (m.valid_o !== 1'b0 || m.data_o !== 8'h00) begin
                failures++; $display("[TB] FAIL mid_after%0d got valid=%b data=%h want 0/00", i, m.valid_o, m.data_o);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;
        m.data_i  = '0; m.valid_i  = 1'b0; m.ready_i  = 1'b0;
        mf.data_i = '0; mf.valid_i = 1'b0; mf.ready_i = 1'b0;
        r1.data_i = '0; r1.valid_i = 1'b0; r1.ready_i = 1'b0;
        $display("[TB] starting bp_serializer tests");
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_msb_first();
        test_ratio1();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
